// File: rtl/id_hazard_scoreboard_pkg.sv
// ---------------------------------------------------------------------------
// id_hazard_scoreboard_pkg
// Shared definitions for the decode-stage issue controller:
//   - sb_state_e   : drain FSM encoding (RUN / DRAIN)
//   - opcode_e     : instruction format classes seen by decode
//   - src_use_t    : which register fields a format reads / writes
//   - decode_use() : maps a format class to its src_use_t
// ---------------------------------------------------------------------------
package id_hazard_scoreboard_pkg;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_DRAIN = 1'b1
    } sb_state_e;

    typedef enum logic [3:0] {
        OP_I1,   // I-type ALU
        OP_I2,   // I-type load
        OP_S,    // store
        OP_R,    // register-register ALU
        OP_BR,   // conditional branch
        OP_J,    // jal
        OP_JR,   // jalr
        OP_U,    // lui
        OP_UPC   // auipc
    } opcode_e;

    typedef struct packed {
        logic uses_rs1;
        logic uses_rs2;
        logic writes_rd;
    } src_use_t;

    // Decode-side helper producing uses_rs1/uses_rs2/writes_rd.
    function automatic src_use_t decode_use(input opcode_e op);
        src_use_t u;
        u = '0;
        case (op)
            OP_I1, OP_I2, OP_JR: u = '{uses_rs1: 1'b1, uses_rs2: 1'b0, writes_rd: 1'b1};
            OP_S, OP_BR:         u = '{uses_rs1: 1'b1, uses_rs2: 1'b1, writes_rd: 1'b0};
            OP_R:                u = '{uses_rs1: 1'b1, uses_rs2: 1'b1, writes_rd: 1'b1};
            OP_J, OP_U, OP_UPC:  u = '{uses_rs1: 1'b0, uses_rs2: 1'b0, writes_rd: 1'b1};
            default:             u = '0;
        endcase
        return u;
    endfunction

endpackage

// File: rtl/id_hazard_scoreboard_sb_counter.sv
// ---------------------------------------------------------------------------
// sb_counter
// Per-register in-flight write counter.
//   clk, rst : clock, asynchronous active-low reset
//   inc      : a tracked write to this register issues
//   dec      : WB writes this register (ignored while the count is 0)
//   cnt      : current count
//   full     : count is at its maximum value
// inc and an effective dec in the same cycle cancel; inc at full holds.
// ---------------------------------------------------------------------------
module sb_counter #(
    parameter int CW = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inc,
    input  logic          dec,
    output logic [CW-1:0] cnt,
    output logic          full
);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          dec_eff;

    assign full    = (cnt_q == '1);
    // Underflow guard: a retire on an idle register must not wrap.
    assign dec_eff = dec && (cnt_q != '0);

    always_comb begin
        cnt_d = cnt_q;
        if (inc && !dec_eff && !full) begin
            cnt_d = cnt_q + CW'(1);
        end else if (dec_eff && !inc) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    // NOTE: state flops use non-blocking assignments so every flop samples
    // pre-edge values, independent of process evaluation order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/id_hazard_scoreboard.sv
// ---------------------------------------------------------------------------
// id_hazard_scoreboard
// Decode-stage issue controller: tracks in-flight register writes between
// ID and WB, holds the decode instruction on RAW / counter-saturation
// hazards, and drains the back-end for fence/system instructions.
// Ports:
//   clk, rst                    : clock, asynchronous active-low reset
//   id_valid                    : decode holds a real instruction
//   rs1, rs2, uses_rs1, uses_rs2: source fields and whether they are read
//   rd, writes_rd               : destination field and whether it is written
//   drain_req                   : decode instruction needs an empty back-end
//   flush                       : decode instruction is squashed
//   RegWrite, rd_WB             : WB register-file write port
//   issue                       : decode instruction advances to EX
//   stall_if, stall_id          : hold PC / IF-ID register
//   bubble_ex                   : load a NOP into ID/EX
//   drain_done                  : one-cycle pulse when a drain completes
//   busy_mask                   : bit r set while register r has writes in flight
//   stall_count                 : running count of stall_id cycles (wraps)
// ---------------------------------------------------------------------------
module id_hazard_scoreboard
    import id_hazard_scoreboard_pkg::*;
#(
    parameter int NREGS = 32,
    parameter int CW    = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [4:0]       rs1,
    input  logic [4:0]       rs2,
    input  logic             uses_rs1,
    input  logic             uses_rs2,
    input  logic [4:0]       rd,
    input  logic             writes_rd,
    input  logic             drain_req,
    input  logic             flush,
    input  logic             RegWrite,
    input  logic [4:0]       rd_WB,
    output logic             issue,
    output logic             stall_if,
    output logic             stall_id,
    output logic             bubble_ex,
    output logic             drain_done,
    output logic [NREGS-1:0] busy_mask,
    output logic [31:0]      stall_count
);

    sb_state_e state_q, state_d;
    logic [31:0] stall_count_q, stall_count_d;

    logic [NREGS-1:0][CW-1:0] cnt_all;
    logic [NREGS-1:0]         full_all;
    logic [NREGS-1:0]         busy;
    logic [NREGS-1:0]         ret_onehot;

    logic retire;
    logic rs1_pend, rs2_pend;
    logic haz, sat, drain_empty;
    logic stall;

    // x0 is hard-wired to an idle counter.
    assign cnt_all[0]  = '0;
    assign full_all[0] = 1'b0;

    for (genvar r = 1; r < NREGS; r++) begin : g_cnt
        sb_counter #(.CW(CW)) u_cnt (
            .clk  (clk),
            .rst  (rst),
            .inc  (issue && writes_rd && (rd == 5'(r))),
            .dec  (RegWrite && (rd_WB == 5'(r))),
            .cnt  (cnt_all[r]),
            .full (full_all[r])
        );
    end

    always_comb begin
        busy = '0;
        for (int r = 1; r < NREGS; r++) begin
            busy[r] = (cnt_all[r] != '0);
        end
    end

    // Effective retire: WB to a tracked register that actually has a write
    // in flight.
    assign retire     = RegWrite && (rd_WB != '0) && (cnt_all[rd_WB] != '0);
    assign ret_onehot = retire ? (NREGS'(1) << rd_WB) : '0;

    // Same-cycle WB bypass: the retiring write does not count as pending.
    assign rs1_pend = (retire && rd_WB == rs1) ? (cnt_all[rs1] > CW'(1))
                                               : (cnt_all[rs1] != '0);
    assign rs2_pend = (retire && rd_WB == rs2) ? (cnt_all[rs2] > CW'(1))
                                               : (cnt_all[rs2] != '0);

    assign haz = (uses_rs1 && rs1 != '0 && rs1_pend) ||
                 (uses_rs2 && rs2 != '0 && rs2_pend);

    assign sat = writes_rd && rd != '0 && full_all[rd] &&
                 !(retire && rd_WB == rd);

    // Every counter reaches zero after this cycle's retire: no other register
    // busy, and the retiring one (if any) holds its last write.
    assign drain_empty = ((busy & ~ret_onehot) == '0) &&
                         (!retire || cnt_all[rd_WB] == CW'(1));

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        state_d    = state_q;
        issue      = 1'b0;
        drain_done = 1'b0;
        stall      = 1'b0;
        // Outputs stay quiet while reset is asserted.
        if (rst) begin
            case (state_q)
                ST_RUN: begin
                    if (id_valid && !flush) begin
                        if (drain_req) begin
                            state_d = ST_DRAIN;
                            stall   = 1'b1;
                        end else if (!haz && !sat) begin
                            issue = 1'b1;
                        end else begin
                            stall = 1'b1;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (flush) begin
                        state_d = ST_RUN;
                    end else if (drain_empty) begin
                        // The drain instruction issues itself on completion.
                        state_d    = ST_RUN;
                        issue      = 1'b1;
                        drain_done = 1'b1;
                    end else begin
                        stall = 1'b1;
                    end
                end
                default: state_d = ST_RUN;
            endcase
        end
    end

    assign stall_id  = stall;
    assign stall_if  = stall;
    assign bubble_ex = !issue;

    assign stall_count_d = stall_count_q + {31'd0, stall};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_RUN;
            stall_count_q <= '0;
        end else begin
            state_q       <= state_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign busy_mask   = busy;
    assign stall_count = stall_count_q;

endmodule

// File: tb/tb_id_hazard_scoreboard.sv
// ---------------------------------------------------------------------------
// tb_id_hazard_scoreboard
// Directed bench for id_hazard_scoreboard. Inputs change 1 time unit after
// the rising edge; outputs are sampled 1 unit later, well before the next
// edge. Expected values are hand-computed per cycle.
// ---------------------------------------------------------------------------
module tb_id_hazard_scoreboard;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [4:0]  rs1, rs2, rd, rd_WB;
    logic        uses_rs1, uses_rs2, writes_rd;
    logic        drain_req, flush, RegWrite;
    logic        issue, stall_if, stall_id, bubble_ex, drain_done;
    logic [31:0] busy_mask;
    logic [31:0] stall_count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    id_hazard_scoreboard #(.NREGS(32), .CW(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .id_valid    (id_valid),
        .rs1         (rs1),
        .rs2         (rs2),
        .uses_rs1    (uses_rs1),
        .uses_rs2    (uses_rs2),
        .rd          (rd),
        .writes_rd   (writes_rd),
        .drain_req   (drain_req),
        .flush       (flush),
        .RegWrite    (RegWrite),
        .rd_WB       (rd_WB),
        .issue       (issue),
        .stall_if    (stall_if),
        .stall_id    (stall_id),
        .bubble_ex   (bubble_ex),
        .drain_done  (drain_done),
        .busy_mask   (busy_mask),
        .stall_count (stall_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic set_id(input logic v, input logic [4:0] a, input logic ua,
                          input logic [4:0] b, input logic ub,
                          input logic [4:0] d, input logic wd,
                          input logic dr, input logic fl);
        id_valid  = v;
        rs1       = a;
        uses_rs1  = ua;
        rs2       = b;
        uses_rs2  = ub;
        rd        = d;
        writes_rd = wd;
        drain_req = dr;
        flush     = fl;
    endtask

    task automatic set_wb(input logic w, input logic [4:0] r);
        RegWrite = w;
        rd_WB    = r;
    endtask

    task automatic idle();
        set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        set_wb(1'b0, 5'd0);
    endtask

    // Plain R-type: rd = rs1 op rs2.
    task automatic r_op(input logic [4:0] d, input logic [4:0] a, input logic [4:0] b);
        set_id(1'b1, a, 1'b1, b, 1'b1, d, 1'b1, 1'b0, 1'b0);
    endtask

    // fence-like drain instruction: reads nothing, writes nothing.
    task automatic drain_op();
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // ---------------- reset with random inputs ----------------
        rst = 1'b0;
        idle();
        for (int i = 0; i < 4; i++) begin
            set_id(1'($urandom), 5'($urandom), 1'($urandom), 5'($urandom), 1'($urandom),
                   5'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            set_wb(1'($urandom), 5'($urandom));
            settle();
            check("rst_issue", {31'd0, issue}, 32'd0);
            check("rst_bubble", {31'd0, bubble_ex}, 32'd1);
            check("rst_stall", {31'd0, stall_id}, 32'd0);
            check("rst_done", {31'd0, drain_done}, 32'd0);
            tick();
            check("rst_busy", busy_mask, 32'd0);
            check("rst_scount", stall_count, 32'd0);
        end
        idle();
        tick();
        rst = 1'b1;
        tick();

        // ---------------- first issue: add x5,x1,x2 ----------------
        r_op(5'd5, 5'd1, 5'd2);
        settle();
        check("add5_issue", {31'd0, issue}, 32'd1);
        check("add5_bubble", {31'd0, bubble_ex}, 32'd0);
        tick();
        check("add5_busy", busy_mask, 32'h0000_0020);
        idle();
        set_wb(1'b1, 5'd5);
        settle();
        check("idle_bubble", {31'd0, bubble_ex}, 32'd1);
        check("idle_stall", {31'd0, stall_id}, 32'd0);
        tick();
        check("ret5_busy", busy_mask, 32'd0);

        // ---------------- RAW: lw x5 ; add x6,x5,x1 ----------------
        set_id(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0);
        set_wb(1'b0, 5'd0);
        settle();
        check("lw_issue", {31'd0, issue}, 32'd1);
        tick();
        r_op(5'd6, 5'd5, 5'd1);
        for (int c = 1; c <= 2; c++) begin
            settle();
            check("raw_stall_id", {31'd0, stall_id}, 32'd1);
            check("raw_stall_if", {31'd0, stall_if}, 32'd1);
            check("raw_issue", {31'd0, issue}, 32'd0);
            check("raw_bubble", {31'd0, bubble_ex}, 32'd1);
            tick();
        end
        set_wb(1'b1, 5'd5);
        settle();
        check("raw_wb_issue", {31'd0, issue}, 32'd1);
        check("raw_wb_stall", {31'd0, stall_id}, 32'd0);
        tick();
        check("raw_busy", busy_mask, 32'h0000_0040);
        check("raw_scount", stall_count, 32'd2);
        idle();
        set_wb(1'b1, 5'd6);
        tick();
        check("ret6_busy", busy_mask, 32'd0);

        // ---------------- saturation on x9 ----------------
        for (int k = 0; k < 3; k++) begin
            set_id(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0);
            set_wb(1'b0, 5'd0);
            settle();
            check("sat_fill_issue", {31'd0, issue}, 32'd1);
            tick();
        end
        check("sat_busy", busy_mask, 32'h0000_0200);
        settle();
        check("sat_stall", {31'd0, stall_id}, 32'd1);
        check("sat_issue", {31'd0, issue}, 32'd0);
        tick();
        check("sat_scount", stall_count, 32'd3);

        // ---------------- x0 and non-readers while cnt[9]=3 ----------------
        set_id(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);   // addi x0,x0,1
        settle();
        check("x0_issue", {31'd0, issue}, 32'd1);
        tick();
        check("x0_busy", busy_mask, 32'h0000_0200);
        set_id(1'b1, 5'd9, 1'b0, 5'd9, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0);   // lui x7
        settle();
        check("lui_issue", {31'd0, issue}, 32'd1);
        tick();
        set_id(1'b1, 5'd1, 1'b1, 5'd9, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0);   // addi x8,x1 (rs2 field = 9)
        settle();
        check("itype_issue", {31'd0, issue}, 32'd1);
        tick();
        check("nonread_busy", busy_mask, 32'h0000_0380);

        // Fourth write to x9 with a same-cycle WB to x9 issues; count stays 3.
        set_id(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0);
        set_wb(1'b1, 5'd9);
        settle();
        check("sat_wb_issue", {31'd0, issue}, 32'd1);
        tick();
        set_wb(1'b0, 5'd0);
        settle();
        check("sat_again_stall", {31'd0, stall_id}, 32'd1);
        tick();
        idle();
        set_wb(1'b1, 5'd7);
        tick();
        set_wb(1'b1, 5'd8);
        tick();
        check("ret78_busy", busy_mask, 32'h0000_0200);
        set_wb(1'b1, 5'd9);
        tick();
        tick();
        check("ret9_two_busy", busy_mask, 32'h0000_0200);
        tick();
        check("ret9_three_busy", busy_mask, 32'd0);
        check("sat_scount2", stall_count, 32'd4);

        // ---------------- drain with two writes in flight ----------------
        set_wb(1'b0, 5'd0);
        r_op(5'd10, 5'd1, 5'd2);
        tick();
        r_op(5'd11, 5'd1, 5'd2);
        tick();
        check("drain_pre_busy", busy_mask, 32'h0000_0C00);
        drain_op();
        settle();
        check("drain0_stall", {31'd0, stall_id}, 32'd1);
        check("drain0_issue", {31'd0, issue}, 32'd0);
        tick();
        set_wb(1'b1, 5'd10);
        settle();
        check("drain1_stall", {31'd0, stall_id}, 32'd1);
        check("drain1_done", {31'd0, drain_done}, 32'd0);
        tick();
        set_wb(1'b0, 5'd0);
        settle();
        check("drain2_stall", {31'd0, stall_if}, 32'd1);
        tick();
        set_wb(1'b1, 5'd11);
        settle();
        check("drain3_done", {31'd0, drain_done}, 32'd1);
        check("drain3_issue", {31'd0, issue}, 32'd1);
        check("drain3_stall", {31'd0, stall_id}, 32'd0);
        check("drain3_bubble", {31'd0, bubble_ex}, 32'd0);
        tick();
        check("drain_scount", stall_count, 32'd7);
        check("drain_busy", busy_mask, 32'd0);
        idle();
        settle();
        check("drain_pulse_off", {31'd0, drain_done}, 32'd0);
        tick();

        // ---------------- drain with empty scoreboard ----------------
        drain_op();
        settle();
        check("edrain0_stall", {31'd0, stall_id}, 32'd1);
        tick();
        settle();
        check("edrain1_done", {31'd0, drain_done}, 32'd1);
        tick();
        check("edrain_scount", stall_count, 32'd8);

        // ---------------- flush during drain ----------------
        r_op(5'd13, 5'd1, 5'd2);
        tick();
        drain_op();
        tick();
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
        settle();
        check("fdrain_stall", {31'd0, stall_id}, 32'd0);
        check("fdrain_issue", {31'd0, issue}, 32'd0);
        check("fdrain_done", {31'd0, drain_done}, 32'd0);
        tick();
        r_op(5'd14, 5'd1, 5'd2);
        settle();
        check("fdrain_run_issue", {31'd0, issue}, 32'd1);
        tick();
        check("fdrain_busy", busy_mask, 32'h0000_6000);
        check("fdrain_scount", stall_count, 32'd9);

        // Flush in RUN on a hazarding instruction: no stall, no tracking.
        set_id(1'b1, 5'd13, 1'b1, 5'd2, 1'b1, 5'd15, 1'b1, 1'b0, 1'b1);
        settle();
        check("flush_stall", {31'd0, stall_id}, 32'd0);
        check("flush_issue", {31'd0, issue}, 32'd0);
        tick();
        check("flush_busy", busy_mask, 32'h0000_6000);

        // ---------------- spurious retire ----------------
        idle();
        set_wb(1'b1, 5'd12);
        tick();
        check("spur_busy", busy_mask, 32'h0000_6000);
        set_wb(1'b0, 5'd0);
        r_op(5'd12, 5'd1, 5'd2);
        tick();
        check("spur_inc_busy", busy_mask, 32'h0000_7000);
        idle();
        set_wb(1'b1, 5'd12);
        tick();
        check("spur_nowrap_busy", busy_mask, 32'h0000_6000);
        check("spur_scount", stall_count, 32'd9);

        // ---------------- reset in the middle of a drain ----------------
        idle();
        drain_op();
        tick();
        check("rdrain_scount", stall_count, 32'd10);
        rst = 1'b0;
        settle();
        check("rdrain_done", {31'd0, drain_done}, 32'd0);
        check("rdrain_busy", busy_mask, 32'd0);
        check("rdrain_scount0", stall_count, 32'd0);
        idle();
        tick();
        rst = 1'b1;
        tick();
        r_op(5'd3, 5'd1, 5'd2);
        settle();
        check("rdrain_run_issue", {31'd0, issue}, 32'd1);
        check("rdrain_run_done", {31'd0, drain_done}, 32'd0);
        tick();
        check("rdrain_run_busy", busy_mask, 32'h0000_0008);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/id_hazard_scoreboard.md
# id_hazard_scoreboard

Issue controller for the decode stage of the pipelined core. Tracks which architectural registers have writes in flight between ID and WB, and holds the decode instruction while it reads a pending source. Generates the front-end stall and EX bubble signals, and runs a drain sequence used for fence/system instructions. Sits beside the decode stage, observes the decoded fields and the WB write port, and drives the IF/ID hold and ID/EX bubble controls.

## Interface
- `NREGS`, 32: number of architectural registers. x0 is never tracked.
- `CW`, 2: per-register in-flight counter width. Saturation at 2^CW−1 forces a stall.
- `clk` in 1: pipeline clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `id_valid` in 1: decode stage holds a real instruction.
- `rs1`, `rs2` in 5 each: source register fields of the decode instruction.
- `uses_rs1`, `uses_rs2` in 1 each: the instruction reads that source. Low for U/J formats and the rs2 of I-type.
- `rd` in 5: destination field.
- `writes_rd` in 1: the instruction writes `rd`. Low for S/BR.
- `drain_req` in 1: the decode instruction is a fence/ecall and needs an empty back-end.
- `flush` in 1: EX resolved a taken branch or jump, so the decode instruction is squashed.
- `RegWrite` in 1, `rd_WB` in 5: WB write port, the same signals that feed the register file.
- `issue` out 1: the decode instruction advances to EX this cycle.
- `stall_if` out 1: hold the PC.
- `stall_id` out 1: hold the IF/ID register.
- `bubble_ex` out 1: load a NOP into ID/EX.
- `drain_done` out 1: one-cycle pulse when a drain completes.
- `busy_mask` out NREGS: bit r is set when cnt[r] != 0. Bit 0 is always 0.
- `stall_count` out 32: total cycles with `stall_id` high.

## Operation
- **State:**
  - cnt[1..NREGS-1] is a CW-bit counter per register.
  - A 2-state FSM: RUN and DRAIN.
- **Retire:** `RegWrite && rd_WB != 0 && cnt[rd_WB] != 0` decrements cnt[rd_WB]. A retire on a register whose count is 0 is ignored; it must not wrap.
- **Hazard:** `haz = (uses_rs1 && rs1 != 0 && pend(rs1)) || (uses_rs2 && rs2 != 0 && pend(rs2))`.
  - `pend(r) = cnt[r] > (retire_r ? 1 : 0)`, where retire_r is a retire to r in the same cycle. This is the same-cycle WB bypass; the register file supplies write-before-read data.
- **Structural hazard:** `sat = writes_rd && rd != 0 && cnt[rd] == 2^CW−1 && !retire_rd`.
- **Issue in RUN:** `issue = id_valid && !flush && !haz && !sat && !drain_req`.
  - On issue with `writes_rd && rd != 0`, cnt[rd] increments.
  - Increment and retire to the same register in the same cycle leave the count unchanged.
- **Stall outputs:**
  - `stall_id = stall_if = id_valid && !flush && !issue`.
  - `bubble_ex = !issue`.
  - On `flush`, no stall is raised and no counter changes from the squashed instruction.
- **Drain FSM:**
  - RUN → DRAIN when `id_valid && drain_req && !flush`. No issue happens that cycle, and the stall outputs are asserted.
  - In DRAIN: the stall outputs are held high and issue is forbidden. Retires continue.
  - DRAIN → RUN on the first cycle all counters are 0 after that cycle's retire. That cycle `drain_done=1` and `issue=1`; the drain instruction issues itself and is not tracked unless `writes_rd`. Stall outputs drop that cycle.
  - `flush` in DRAIN → RUN immediately. No `drain_done`, no issue.
- **stall_count:** increments on every cycle with `stall_id` high and wraps modulo 2^32.
- **Reset** (async assert, synchronous deassert handled by the reset tree):
  - All cnt = 0, state = RUN, `stall_count` = 0.
  - Resulting outputs: `issue=0`, `stall_if=stall_id=0`, `bubble_ex=1`, `drain_done=0`, `busy_mask=0`.
  - Reset mid-drain returns to RUN with no pulse.

## Timing
- The outputs `issue`, `stall_*`, `bubble_ex` and `drain_done` are combinational from inputs and current state. They must settle in the same cycle; there are no registered outputs besides `busy_mask` and `stall_count`, which reflect state after the last edge.
- Counter and FSM updates occur on the rising `clk`.
- Load-use with no forwarding: the consumer stalls until the producer's WB cycle, issuing in that same cycle through the bypass.
  - Back-to-back dependent instructions stall 2 cycles: the producer is in EX, then MEM, then WB.
- A drain completing with an empty scoreboard takes 1 stall cycle minimum (RUN→DRAIN, then DRAIN→RUN).

## Structure
- The shared core package holds:
  - the opcode constants (I1, I2, S, R, BR, J, JR, U, UPC), for decode-side generation of `uses_rs*` and `writes_rd`;
  - the FSM state encoding: RUN=1'b0, DRAIN=1'b1.
- One sub-module, `sb_counter`: a CW-bit up/down counter with saturation and underflow guard, instantiated NREGS−1 times via generate.

## Test plan
- **Reset:** hold `rst`=0 with random inputs → `busy_mask`=0, `stall_count`=0, `bubble_ex`=1, `issue`=0. Release, then issue `add x5` → cnt[5]=1, `busy_mask`=0x20.
- **RAW:** issue `lw x5` at cycle 0; `add x6,x5,x1` in ID from cycle 1, with WB writes x5 at cycle 3 → `stall_id`=1 in cycles 1–2 and `issue`=1 at cycle 3; `stall_count`=2.
- **x0 and non-readers:** `addi x0,x0,1` then `lui x7` while cnt[*]=3 on other registers → no stall, `busy_mask` bit 0 stays 0.
- **Saturation:** issue three writes to x9 with no WB → the fourth write to x9 stalls. A WB to x9 in the same cycle lets it issue, and cnt[9] stays 3.
- **Drain:** 2 writes in flight, `drain_req` asserted, WB retires at cycles +1 and +3 → `drain_done`/`issue` pulse at +3, stall for exactly 3 cycles.
- **Flush during drain / spurious retire:** `flush` in DRAIN → RUN, no `drain_done`. `RegWrite` to x12 with cnt[12]=0 → cnt stays 0.
